arbiter_encoder_rr: RTL and testbench

Parametrised N-way request arbiter with a registered one-hot grant and a binary-encoded grant index.
- Generalises the 4-way combinational lowest-index arbiter and encoder pair to N requesters.
- Adds a selectable round-robin mode and grant locking until the winner releases its request.
- Sits between N bus masters and a shared resource (UART/SPI/RAM port) on the icestick fabric. Downstream muxes steer on GNT_IDX while GNT_VALID is high.

---
 rtl/arbiter_encoder_rr.sv | 141 ++++++++++++++
 tb/tb_arbiter_encoder_rr.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_encoder_rr.sv
// N-way request arbiter: registered one-hot grant plus encoded index, fixed or round-robin
// priority, grant locked until release. Optional grant timeout under ARB_TIMEOUT_EN.
module arbiter_encoder_rr #(
  parameter int unsigned  N        = 4,
  parameter bit           RR_MODE  = 1'b1,
  parameter int unsigned  MAX_HOLD = 16,
  localparam int unsigned W        = $clog2(N)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] gnt_idx_o,
  output logic         gnt_valid_o,
  output logic         timeout_o
);

  if (N < 2 || MAX_HOLD < 2) begin : gen_param_check
    $error("arbiter_encoder_rr: N and MAX_HOLD must both be >= 2");
  end

  typedef enum logic {StIdle, StGrant} state_e;

  state_e      state_q;
  logic [N-1:0] gnt_q;
  logic [W-1:0] idx_q;
  logic         valid_q;
  logic [W-1:0] ptr_q;

  logic         win_found;
  logic [W-1:0] win_idx;
  logic [W-1:0] cand_w;
  int unsigned  cand;
  logic [N-1:0] win_onehot;
  logic [W-1:0] ptr_next;

  // Scan starts at the rotation pointer in round-robin mode, at 0 otherwise.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_w    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = RR_MODE ? 32'(ptr_q) + k : k;
      if (cand >= N) cand = cand - N;
      cand_w = W'(cand);
      if (!win_found && req_i[cand_w]) begin
        win_found = 1'b1;
        win_idx   = cand_w;
      end
    end
  end

  assign win_onehot = {{(N-1){1'b0}}, 1'b1} << win_idx;
  assign ptr_next   = (idx_q == W'(N - 1)) ? '0 : idx_q + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HoldLast = HW'(MAX_HOLD - 1);

  logic [HW-1:0] hold_q;
  logic          timeout_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      ptr_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            state_q <= StGrant;
            gnt_q   <= win_onehot;
            idx_q   <= win_idx;
            valid_q <= 1'b1;
            hold_q  <= '0;
          end
        end
        StGrant: begin
          // A voluntary release on the timeout edge takes precedence and is not flagged.
          if (!req_i[idx_q] || hold_q == HoldLast) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            ptr_q     <= ptr_next;
            timeout_q <= req_i[idx_q];
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign timeout_o = timeout_q;
`else
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            state_q <= StGrant;
            gnt_q   <= win_onehot;
            idx_q   <= win_idx;
            valid_q <= 1'b1;
          end
        end
        StGrant: begin
          if (!req_i[idx_q]) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= ptr_next;
          end
        end
      endcase
    end
  end

  assign timeout_o = 1'b0;
`endif

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = idx_q;
  assign gnt_valid_o = valid_q;

endmodule

// File: tb/tb_arbiter_encoder_rr.sv
// Bench for arbiter_encoder_rr: fixed-priority N=4, round-robin N=4 and round-robin N=3 instances
// driven together and compared each cycle with a behavioural model.
module tb_arbiter_encoder_rr;

  localparam int MaxHold = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_f, gnt_f, req_r, gnt_r;
  logic [2:0] req_3, gnt_3;
  logic [1:0] idx_f, idx_r, idx_3;
  logic       val_f, val_r, val_3, to_f, to_r, to_3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  arbiter_encoder_rr #(.N(4), .RR_MODE(1'b0), .MAX_HOLD(MaxHold)) u_fix (
    .clk_i(clk), .rst_i(rst), .req_i(req_f), .gnt_o(gnt_f), .gnt_idx_o(idx_f),
    .gnt_valid_o(val_f), .timeout_o(to_f));
  arbiter_encoder_rr #(.N(4), .RR_MODE(1'b1), .MAX_HOLD(MaxHold)) u_rr4 (
    .clk_i(clk), .rst_i(rst), .req_i(req_r), .gnt_o(gnt_r), .gnt_idx_o(idx_r),
    .gnt_valid_o(val_r), .timeout_o(to_r));
  arbiter_encoder_rr #(.N(3), .RR_MODE(1'b1), .MAX_HOLD(MaxHold)) u_rr3 (
    .clk_i(clk), .rst_i(rst), .req_i(req_3), .gnt_o(gnt_3), .gnt_idx_o(idx_3),
    .gnt_valid_o(val_3), .timeout_o(to_3));

  // Model: owner = -1 when idle, held = cycles the grant has been visible so far.
  typedef struct {
    int owner;
    int ptr;
    int held;
    bit to;
  } model_t;

  localparam model_t ModelRst = '{owner: -1, ptr: 0, held: 0, to: 1'b0};
  model_t m_f, m_r, m_3;

  function automatic model_t step(model_t m, logic [3:0] req, int n, bit rr);
    model_t r;
    int c;
    r = m;
    r.to = 1'b0;
    if (m.owner < 0) begin
      for (int k = 0; k < n; k++) begin
        c = rr ? (m.ptr + k) % n : k;
        if (r.owner < 0 && req[c]) begin
          r.owner = c;
          r.held  = 1;
        end
      end
    end else if (!req[m.owner] || (ToEn && m.held == MaxHold)) begin
      r.to    = req[m.owner];
      r.ptr   = (m.owner + 1) % n;
      r.owner = -1;
    end else begin
      r.held = m.held + 1;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag, input model_t m, input logic [3:0] gnt,
                           input logic [1:0] idx, input logic v, input logic to);
    logic [3:0] e_gnt;
    e_gnt = (m.owner >= 0) ? 4'(1 << m.owner) : 4'b0000;
    chk({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
    chk({tag, ".idx"}, 32'(idx), (m.owner >= 0) ? 32'(m.owner) : 32'd0);
    chk({tag, ".valid"}, 32'(v), 32'(m.owner >= 0));
    chk({tag, ".timeout"}, 32'(to), 32'(m.to));
  endtask

  task automatic chk_all();
    chk_model("fix4", m_f, gnt_f, idx_f, val_f, to_f);
    chk_model("rr4", m_r, gnt_r, idx_r, val_r, to_r);
    chk_model("rr3", m_3, {1'b0, gnt_3}, idx_3, val_3, to_3);
  endtask

  // Called away from the edge; returns 1 ns after the next rising edge.
  task automatic tick(input logic [3:0] rf, input logic [3:0] rr, input logic [2:0] r3);
    req_f = rf;
    req_r = rr;
    req_3 = r3;
    @(posedge clk);
    #1;
    m_f = step(m_f, rf, 4, 1'b0);
    m_r = step(m_r, rr, 4, 1'b1);
    m_3 = step(m_3, {1'b0, r3}, 3, 1'b1);
    chk_all();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_f = '0;
    req_r = '0;
    req_3 = '0;
    @(posedge clk);
    #1;
    m_f = ModelRst;
    m_r = ModelRst;
    m_3 = ModelRst;
    chk_all();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
  } vec_t;

  vec_t tbl [10];
  int   rr_seq [5];
  logic [3:0] rq4f, rq4r;
  logic [2:0] rq3;

  initial begin
    tbl[0] = '{4'b1010, 4'b0010, 2'd1, 1'b1};
    tbl[1] = '{4'b0010, 4'b0010, 2'd1, 1'b1};
    tbl[2] = '{4'b1010, 4'b0010, 2'd1, 1'b1};
    tbl[3] = '{4'b0010, 4'b0010, 2'd1, 1'b1};
    tbl[4] = '{4'b1010, 4'b0010, 2'd1, 1'b1};
    tbl[5] = '{4'b1000, 4'b0000, 2'd0, 1'b0};
    tbl[6] = '{4'b1000, 4'b1000, 2'd3, 1'b1};
    tbl[7] = '{4'b1000, 4'b1000, 2'd3, 1'b1};
    tbl[8] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[9] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    rr_seq = '{0, 1, 2, 3, 0};

    // Asynchronous reset in the middle of a grant.
    do_reset();
    tick(4'b0000, 4'b0100, 3'b000);
    chk("rst.pre_gnt", 32'(gnt_r), 32'h4);
    #3;
    rst = 1'b1;
    #1;
    m_f = ModelRst;
    m_r = ModelRst;
    m_3 = ModelRst;
    chk_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(4'b0000, 4'b0001, 3'b000);
    chk("rst.post_gnt", 32'(gnt_r), 32'h1);

    // Fixed priority, grant locked while REQ[3] toggles.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick(tbl[i].req, 4'b0000, 3'b000);
      chk($sformatf("fix.gnt[%0d]", i), 32'(gnt_f), 32'(tbl[i].gnt));
      chk($sformatf("fix.idx[%0d]", i), 32'(idx_f), 32'(tbl[i].idx));
      chk($sformatf("fix.valid[%0d]", i), 32'(val_f), 32'(tbl[i].valid));
    end

    // Round-robin rotation with every requester active.
    do_reset();
    for (int g = 0; g < 5; g++) begin
      tick(4'b0000, 4'b1111, 3'b000);
      chk($sformatf("rr.idx[%0d]", g), 32'(idx_r), 32'(rr_seq[g]));
      chk($sformatf("rr.valid[%0d]", g), 32'(val_r), 32'd1);
      tick(4'b0000, 4'b1111 & ~(4'b0001 << rr_seq[g]), 3'b000);
      chk($sformatf("rr.gap[%0d]", g), 32'(val_r), 32'd0);
    end

    // Pointer wrap on a three-way arbiter.
    do_reset();
    tick(4'b0000, 4'b0000, 3'b100);
    chk("wrap.idx2", 32'(idx_3), 32'd2);
    tick(4'b0000, 4'b0000, 3'b000);
    tick(4'b0000, 4'b0000, 3'b011);
    chk("wrap.idx0", 32'(idx_3), 32'd0);
    tick(4'b0000, 4'b0000, 3'b010);
    chk("wrap.rel", 32'(val_3), 32'd0);
    tick(4'b0000, 4'b0000, 3'b011);
    chk("wrap.idx1", 32'(idx_3), 32'd1);

    // Holding a request: forced release with timeout, or indefinite grant.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      tick(4'b0000, 4'b0001, 3'b000);
      chk($sformatf("hold.valid[%0d]", c), 32'(val_r), 32'd1);
    end
`ifdef ARB_TIMEOUT_EN
    tick(4'b0000, 4'b0001, 3'b000);
    chk("to.valid", 32'(val_r), 32'd0);
    chk("to.pulse", 32'(to_r), 32'd1);
    tick(4'b0000, 4'b0011, 3'b000);
    chk("to.next_idx", 32'(idx_r), 32'd1);
    chk("to.pulse_end", 32'(to_r), 32'd0);

    do_reset();
    for (int c = 0; c < 4; c++) tick(4'b0000, 4'b0001, 3'b000);
    tick(4'b0000, 4'b0000, 3'b000);
    chk("to.same_edge_valid", 32'(val_r), 32'd0);
    chk("to.same_edge_pulse", 32'(to_r), 32'd0);
`else
    for (int c = 0; c < 12; c++) begin
      tick(4'b0000, 4'b0001, 3'b000);
      chk($sformatf("nto.valid[%0d]", c), 32'(val_r), 32'd1);
      chk($sformatf("nto.pulse[%0d]", c), 32'(to_r), 32'd0);
    end
`endif

    // Random traffic: each request bit flips with probability 1/4 per cycle.
    do_reset();
    rq4f = '0;
    rq4r = '0;
    rq3  = '0;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) rq4f[b] = ~rq4f[b];
        if ($urandom_range(0, 3) == 0) rq4r[b] = ~rq4r[b];
        if (b < 3 && $urandom_range(0, 3) == 0) rq3[b] = ~rq3[b];
      end
      tick(rq4f, rq4r, rq3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
